// File: rtl/kl_pipe_pkg.sv
// Shared definitions for the 16-bit pipeline memory-access stage:
// control-word field positions, memory opcodes and the IO handshake states.
package kl_pipe_pkg;

   localparam int CTL_W     = 22;
   localparam int CTL_OP_HI = 21;
   localparam int CTL_OP_LO = 19;

   localparam logic [2:0] OP_LDR = 3'b011;
   localparam logic [2:0] OP_STR = 3'b100;

   // Load value returned when an IO access is abandoned.
   localparam logic [15:0] IO_TIMEOUT_DATA = 16'hDEAD;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_IO_WAIT = 2'd1,
      ST_IO_DONE = 2'd2
   } mem_state_t;

   function automatic logic [2:0] ctl_op(input logic [CTL_W-1:0] ctl);
      return ctl[CTL_OP_HI:CTL_OP_LO];
   endfunction

endpackage

// File: rtl/mem_io_port.sv
// IO handshake sequencer for the memory-access stage: tracks one IO access,
// counts wait cycles, captures the load word and flags timeouts.
module mem_io_port
   import kl_pipe_pkg::*;
#(
   parameter int IO_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        is_io_i,
   input  logic        io_ready_i,
   input  logic [15:0] io_rdata_i,
   output mem_state_t  state_o,
   output logic        io_req_o,
   output logic        stall_o,
   output logic        done_o,
   output logic [15:0] io_rdata_o,
   output logic        io_err_o
);

   localparam int                CNT_W    = $clog2(IO_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

   mem_state_t        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [15:0]       io_rdata_q;
   logic              io_err_q;

   // NOTE: every register here uses <= so all of them see the pre-edge state
   // when the next state is computed, whatever the statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         io_rdata_q <= '0;
         io_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (is_io_i) begin
                  cnt_q <= '0;
                  if (io_ready_i) begin
                     io_rdata_q <= io_rdata_i;
                     state_q    <= ST_IO_DONE;
                  end else begin
                     state_q    <= ST_IO_WAIT;
                  end
               end
            end
            ST_IO_WAIT: begin
               // Ready is tested first so a response on the last allowed cycle wins.
               if (io_ready_i) begin
                  io_rdata_q <= io_rdata_i;
                  state_q    <= ST_IO_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  io_rdata_q <= IO_TIMEOUT_DATA;
                  io_err_q   <= 1'b1;
                  state_q    <= ST_IO_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_IO_DONE: state_q <= ST_RUN;
            default:    state_q <= ST_RUN;
         endcase
      end
   end

   assign io_req_o   = (state_q == ST_IO_WAIT) || ((state_q == ST_RUN) && is_io_i);
   assign stall_o    = io_req_o;
   assign done_o     = (state_q == ST_IO_DONE);
   assign state_o    = state_q;
   assign io_rdata_o = io_rdata_q;
   assign io_err_o   = io_err_q;

endmodule

// File: rtl/pipeline_3_memaccess.sv
// Memory-access stage: registers execute outputs, drives the synchronous data
// RAM, diverts high addresses to the IO port and selects the load word.
module pipeline_3_memaccess
   import kl_pipe_pkg::*;
#(
   parameter int          ADDR_W     = 8,
   parameter logic [7:0]  IO_BASE    = 8'hF0,
   parameter int          IO_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [21:0]       control_in,
   input  logic [15:0]       result_in,
   input  logic [15:0]       sdata_in,
   output logic              stall_out,
   output logic [21:0]       control_out,
   output logic [15:0]       result_out,
   output logic [15:0]       rdata_out,
   output logic [ADDR_W-1:0] ram_addr_out,
   output logic [15:0]       ram_wdata_out,
   output logic              ram_we_out,
   input  logic [15:0]       ram_rdata_in,
   output logic              io_req_out,
   output logic              io_we_out,
   output logic [7:0]        io_addr_out,
   output logic [15:0]       io_wdata_out,
   input  logic              io_ready_in,
   input  logic [15:0]       io_rdata_in,
   output logic              io_err_out
);

   logic [21:0] ctl_q, ctl_d;
   logic [15:0] res_q, res_d;
   logic [15:0] sd_q,  sd_d;
   logic        last_io_q, last_io_d;

   logic        is_ldr, is_str, is_io;
   logic        stall, io_done;
   logic [15:0] io_rdata;
   mem_state_t  io_state;

   // NOTE: defaults first so the hold path is explicit and no latch is inferred.
   always_comb begin
      ctl_d = ctl_q;
      res_d = res_q;
      sd_d  = sd_q;
      if (!stall) begin
         ctl_d = control_in;
         res_d = result_in;
         sd_d  = sdata_in;
      end
   end

   // Set only when the word just issued to writeback came out of the IO port.
   assign last_io_d = io_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctl_q     <= '0;
         res_q     <= '0;
         sd_q      <= '0;
         last_io_q <= 1'b0;
      end else begin
         ctl_q     <= ctl_d;
         res_q     <= res_d;
         sd_q      <= sd_d;
         last_io_q <= last_io_d;
      end
   end

   assign is_ldr = (ctl_op(ctl_q) == OP_LDR);
   assign is_str = (ctl_op(ctl_q) == OP_STR);
   assign is_io  = (is_ldr || is_str) && (res_q[7:0] >= IO_BASE);

   mem_io_port #(
      .IO_TIMEOUT (IO_TIMEOUT)
   ) u_io (
      .clk        (clk),
      .rst        (rst),
      .is_io_i    (is_io),
      .io_ready_i (io_ready_in),
      .io_rdata_i (io_rdata_in),
      .state_o    (io_state),
      .io_req_o   (io_req_out),
      .stall_o    (stall),
      .done_o     (io_done),
      .io_rdata_o (io_rdata),
      .io_err_o   (io_err_out)
   );

   // A RAM store can only fire in RUN, and RUN lasts one cycle per op.
   assign ram_we_out    = (io_state == ST_RUN) && is_str && !is_io;
   assign ram_addr_out  = res_q[ADDR_W-1:0];
   assign ram_wdata_out = sd_q;

   assign io_we_out     = io_req_out && is_str;
   assign io_addr_out   = res_q[7:0];
   assign io_wdata_out  = sd_q;

   assign stall_out     = stall;
   assign control_out   = stall ? '0 : ctl_q;
   assign result_out    = res_q;
   assign rdata_out     = last_io_q ? io_rdata : ram_rdata_in;

endmodule

// File: tb/tb_pipeline_3_memaccess.sv
// Scoreboard bench for pipeline_3_memaccess with a synchronous RAM model and
// a scripted IO responder.
module tb_pipeline_3_memaccess;
   import kl_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [21:0] control_in = '0;
   logic [15:0] result_in  = '0;
   logic [15:0] sdata_in   = '0;
   logic        stall_out;
   logic [21:0] control_out;
   logic [15:0] result_out, rdata_out;
   logic [7:0]  ram_addr_out;
   logic [15:0] ram_wdata_out;
   logic        ram_we_out;
   logic [15:0] ram_rdata_in;
   logic        io_req_out, io_we_out;
   logic [7:0]  io_addr_out;
   logic [15:0] io_wdata_out;
   logic        io_ready_in = 1'b0;
   logic [15:0] io_rdata_in = 16'hFFFF;
   logic        io_err_out;

   pipeline_3_memaccess dut (
      .clk           (clk),
      .rst           (rst),
      .control_in    (control_in),
      .result_in     (result_in),
      .sdata_in      (sdata_in),
      .stall_out     (stall_out),
      .control_out   (control_out),
      .result_out    (result_out),
      .rdata_out     (rdata_out),
      .ram_addr_out  (ram_addr_out),
      .ram_wdata_out (ram_wdata_out),
      .ram_we_out    (ram_we_out),
      .ram_rdata_in  (ram_rdata_in),
      .io_req_out    (io_req_out),
      .io_we_out     (io_we_out),
      .io_addr_out   (io_addr_out),
      .io_wdata_out  (io_wdata_out),
      .io_ready_in   (io_ready_in),
      .io_rdata_in   (io_rdata_in),
      .io_err_out    (io_err_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [21:0] ctl;
      logic [15:0] res;
      bit          is_ld;
      logic [15:0] rdata;
      int          exp_cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stall_run = 0;
   int          stall_runs[$];
   int          we_cnt = 0;
   logic [23:0] we_log[$];
   bit          saw_io_we = 0;
   bit          rd_pending = 0;
   logic [15:0] rd_exp = '0;

   // RAM model: read-first synchronous memory with a registered output.
   logic [15:0] ram [256];
   logic [15:0] ram_rdata_q = '0;
   assign ram_rdata_in = ram_rdata_q;
   always @(posedge clk) begin
      if (ram_we_out) ram[ram_addr_out] <= ram_wdata_out;
      ram_rdata_q <= ram[ram_addr_out];
   end

   // IO responder: ready after io_delay refused request cycles, or never.
   logic [15:0] io_mem [256];
   int          io_delay = 0;
   bit          io_never = 0;
   int          req_cycles = 0;
   always @(negedge clk) begin
      if (io_req_out) begin
         io_ready_in = !io_never && (req_cycles == io_delay);
         io_rdata_in = io_ready_in ? io_mem[io_addr_out] : 16'hFFFF;
         req_cycles++;
      end else begin
         io_ready_in = 1'b0;
         io_rdata_in = 16'hFFFF;
         req_cycles  = 0;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a writeback appears.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         stall_run  = 0;
         rd_pending = 0;
      end else begin
         if (rd_pending) begin
            check("wb_rdata", 32'(rdata_out), 32'(rd_exp));
            rd_pending = 0;
         end
         if (stall_out) begin
            check("ctl_zero_in_stall", 32'(control_out), 32'h0);
            stall_run++;
         end else if (stall_run != 0) begin
            stall_runs.push_back(stall_run);
            stall_run = 0;
         end
         if (control_out != '0) begin
            if (sb.size() == 0) begin
               check("unexpected_wb", 32'(control_out), 32'h0);
            end else begin
               e = sb.pop_front();
               check("wb_ctl", 32'(control_out), 32'(e.ctl));
               check("wb_res", 32'(result_out), 32'(e.res));
               check("wb_cycle", cyc, e.exp_cyc);
               if (e.is_ld) begin
                  rd_pending = 1;
                  rd_exp     = e.rdata;
               end
            end
         end
         if (ram_we_out) begin
            we_cnt++;
            we_log.push_back({ram_addr_out, ram_wdata_out});
         end
         if (io_req_out && io_we_out) saw_io_we = 1;
      end
   end

   // Present one op, wait until the stage accepts it, then record the expectation.
   task automatic issue(input logic [2:0] op, input logic [15:0] res, input logic [15:0] sd,
                        input logic [14:0] tag, input logic [15:0] rexp, input int extra);
      exp_t e;
      bit   ok = 0;
      e.ctl = {op, tag, (op != OP_STR), tag[2:0]};
      control_in = e.ctl;
      result_in  = res;
      sdata_in   = sd;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (!stall_out) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("issue_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      e.res     = res;
      e.is_ld   = (op == OP_LDR);
      e.rdata   = rexp;
      e.exp_cyc = cyc + extra;
      sb.push_back(e);
      control_in = '0;
      result_in  = '0;
      sdata_in   = '0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (sb.size() == 0 && !rd_pending && !stall_out) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("drain_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int we0;
      for (int i = 0; i < 256; i++) begin
         ram[i]    = '0;
         io_mem[i] = 16'h6000 + 16'(i);
      end
      io_mem[8'hF4] = 16'h1234;
      io_mem[8'hF8] = 16'hA5A5;
      io_mem[8'hFC] = 16'h5A5A;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("rst_ctl",     32'(control_out), 32'h0);
      check("rst_res",     32'(result_out),  32'h0);
      check("rst_stall",   32'(stall_out),   32'h0);
      check("rst_ram_we",  32'(ram_we_out),  32'h0);
      check("rst_ram_adr", 32'(ram_addr_out), 32'h0);
      check("rst_io_req",  32'(io_req_out),  32'h0);
      check("rst_io_we",   32'(io_we_out),   32'h0);
      check("rst_io_err",  32'(io_err_out),  32'h0);
      check("rst_rdata",   32'(rdata_out),   32'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      // RAM store/load pass-through, including the last address below IO_BASE
      we0 = we_cnt;
      we_log.delete();
      stall_runs.delete();
      issue(OP_STR, 16'h0012, 16'hBEEF, 15'h001, 16'h0,    0);
      issue(OP_LDR, 16'h0012, 16'h0,    15'h002, 16'hBEEF, 0);
      issue(3'b000, 16'h5555, 16'h0,    15'h003, 16'h0,    0);
      issue(OP_STR, 16'h00EF, 16'h7777, 15'h004, 16'h0,    0);
      issue(OP_LDR, 16'h00EF, 16'h0,    15'h005, 16'h7777, 0);
      drain();
      check("ram_we_count", we_cnt - we0, 2);
      if (we_log.size() == 2) begin
         check("ram_we0", 32'(we_log[0]), 32'({8'h12, 16'hBEEF}));
         check("ram_we1", 32'(we_log[1]), 32'({8'hEF, 16'h7777}));
      end
      check("ram_no_stall", stall_runs.size(), 0);

      // IO load answered on the fourth request cycle
      io_never = 0;
      io_delay = 3;
      stall_runs.delete();
      we0 = we_cnt;
      issue(OP_LDR, 16'h00F4, 16'h0, 15'h010, 16'h1234, 4);
      drain();
      check("io_ld_stall_cnt", stall_runs.size(), 1);
      if (stall_runs.size() > 0) check("io_ld_stall_len", stall_runs[0], 4);
      check("io_ld_no_ram_we", we_cnt - we0, 0);

      // IO store that never completes
      check("io_err_before", 32'(io_err_out), 32'h0);
      io_never = 1;
      saw_io_we = 0;
      stall_runs.delete();
      we0 = we_cnt;
      issue(OP_STR, 16'h00F0, 16'hCAFE, 15'h020, 16'h0, 16);
      drain();
      check("to_str_stall_cnt", stall_runs.size(), 1);
      if (stall_runs.size() > 0) check("to_str_stall_len", stall_runs[0], 16);
      check("io_err_after", 32'(io_err_out), 32'h1);
      check("to_str_no_ram_we", we_cnt - we0, 0);
      check("to_str_io_we", 32'(saw_io_we), 32'h1);

      // IO load that times out returns the filler word
      issue(OP_LDR, 16'h00FF, 16'h0, 15'h021, IO_TIMEOUT_DATA, 16);
      drain();

      // Back-to-back IO loads, then a RAM load right behind them
      io_never = 0;
      io_delay = 0;
      stall_runs.delete();
      issue(OP_LDR, 16'h00F8, 16'h0, 15'h030, 16'hA5A5, 1);
      issue(OP_LDR, 16'h00FC, 16'h0, 15'h031, 16'h5A5A, 1);
      issue(OP_LDR, 16'h0012, 16'h0, 15'h032, 16'hBEEF, 0);
      drain();
      check("b2b_stall_cnt", stall_runs.size(), 2);
      if (stall_runs.size() == 2) begin
         check("b2b_stall0", stall_runs[0], 1);
         check("b2b_stall1", stall_runs[1], 1);
      end

      // Reset in the middle of an IO wait
      io_never = 1;
      issue(OP_LDR, 16'h00F4, 16'h0, 15'h040, 16'h1234, 16);
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_ctl",    32'(control_out), 32'h0);
      check("mid_rst_res",    32'(result_out),  32'h0);
      check("mid_rst_stall",  32'(stall_out),   32'h0);
      check("mid_rst_io_req", 32'(io_req_out),  32'h0);
      check("mid_rst_io_err", 32'(io_err_out),  32'h0);
      check("mid_rst_ram_we", 32'(ram_we_out),  32'h0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      io_never = 0;
      issue(OP_LDR, 16'h0012, 16'h0, 15'h050, 16'hBEEF, 0);
      drain();
      check("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
